// File: rtl/c499_enc.sv
// c499_enc: streaming SEC check-bit generator with a 2-stage valid/ready pipeline.
// Optional single-bit error injection on the stage-1 to stage-2 transfer.
module c499_enc #(
    parameter int CNT_W  = 16,
    parameter int INJ_EN = 1
) (
    input  logic             GCLK,
    input  logic             GRST,
    input  logic             GIVAL,
    output logic             GIRDY,
    input  logic [31:0]      GID,
    input  logic             GINJE,
    input  logic [5:0]       GINJP,
    output logic             GOVAL,
    input  logic             GORDY,
    output logic [31:0]      GOD,
    output logic [7:0]       GOC,
    output logic [CNT_W-1:0] GOCNT
);

    logic             s1_v_q;
    logic [31:0]      s1_d_q;
    logic [7:0]       s1_f_q;
    logic [7:0]       s1_e_q;
    logic             s1_inj_q;
    logic [5:0]       s1_p_q;
    logic             s2_v_q;
    logic [31:0]      s2_d_q;
    logic [7:0]       s2_c_q;
    logic [CNT_W-1:0] cnt_q;

    logic             adv1;
    logic             adv2;
    logic [7:0]       f_d;
    logic [7:0]       e_d;
    logic [7:0]       g;
    logic [7:0]       c;
    logic [31:0]      dmask;
    logic [7:0]       cmask;
    logic [31:0]      s2_d_d;
    logic [7:0]       s2_c_d;
    logic [CNT_W-1:0] cnt_d;

    assign adv2  = !s2_v_q || GORDY;
    assign adv1  = !s1_v_q || adv2;
    assign GIRDY = adv1;

    // Nibble parities and column parities are taken at the input.
    always_comb begin
        f_d = '0;
        e_d = '0;
        for (int k = 0; k < 8; k++) begin
            f_d[k] = ^GID[4*k +: 4];
        end
        for (int i = 0; i < 4; i++) begin
            e_d[i] = GID[i] ^ GID[i+4] ^ GID[i+8] ^ GID[i+12];
        end
        for (int i = 4; i < 8; i++) begin
            e_d[i] = GID[i+12] ^ GID[i+16] ^ GID[i+20] ^ GID[i+24];
        end
    end

    always_comb begin
        g[0] = s1_f_q[0] ^ s1_f_q[1];
        g[1] = s1_f_q[2] ^ s1_f_q[3];
        g[2] = s1_f_q[0] ^ s1_f_q[2];
        g[3] = s1_f_q[1] ^ s1_f_q[3];
        g[4] = s1_f_q[4] ^ s1_f_q[5];
        g[5] = s1_f_q[6] ^ s1_f_q[7];
        g[6] = s1_f_q[4] ^ s1_f_q[6];
        g[7] = s1_f_q[5] ^ s1_f_q[7];
        c[3:0] = s1_e_q[3:0] ^ g[7:4];
        c[7:4] = s1_e_q[7:4] ^ g[3:0];
    end

    // Positions 32..39 address check bits; 40..63 flip nothing.
    always_comb begin
        dmask = '0;
        cmask = '0;
        if ((INJ_EN != 0) && s1_inj_q) begin
            if (!s1_p_q[5]) begin
                dmask[s1_p_q[4:0]] = 1'b1;
            end else if (s1_p_q[4:3] == 2'b00) begin
                cmask[s1_p_q[2:0]] = 1'b1;
            end
        end
        s2_d_d = s1_d_q ^ dmask;
        s2_c_d = c ^ cmask;
    end

    assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, (s2_v_q && GORDY)};

    always_ff @(posedge GCLK) begin
        if (GRST) begin
            s1_v_q   <= 1'b0;
            s1_d_q   <= '0;
            s1_f_q   <= '0;
            s1_e_q   <= '0;
            s1_inj_q <= 1'b0;
            s1_p_q   <= '0;
            s2_v_q   <= 1'b0;
            s2_d_q   <= '0;
            s2_c_q   <= '0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (adv1) begin
                s1_v_q   <= GIVAL;
                s1_inj_q <= GIVAL && GINJE;
                if (GIVAL) begin
                    s1_d_q <= GID;
                    s1_f_q <= f_d;
                    s1_e_q <= e_d;
                    s1_p_q <= GINJP;
                end
            end
            if (adv2) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) begin
                    s2_d_q <= s2_d_d;
                    s2_c_q <= s2_c_d;
                end
            end
        end
    end

    assign GOVAL = s2_v_q;
    assign GOD   = s2_d_q;
    assign GOC   = s2_c_q;
    assign GOCNT = cnt_q;

endmodule

// File: tb/tb_c499_enc.sv
// tb_c499_enc: directed vectors, stall/order, reset flush and counter wrap
// for c499_enc; a reference encoder/corrector is built from the equations.
module tb_c499_enc;

    logic        GCLK = 1'b0;
    logic        GRST = 1'b1;
    logic        GIVAL = 1'b0;
    logic [31:0] GID = '0;
    logic        GINJE = 1'b0;
    logic [5:0]  GINJP = '0;
    logic        GORDY = 1'b1;

    logic        GIRDY, GOVAL;
    logic [31:0] GOD;
    logic [7:0]  GOC;
    logic [3:0]  GOCNT;

    logic        GIRDY1, GOVAL1;
    logic [31:0] GOD1;
    logic [7:0]  GOC1;
    logic [15:0] GOCNT1;

    int ncmp = 0;
    int nfail = 0;

    always #5 GCLK = ~GCLK;

    c499_enc #(.CNT_W(4), .INJ_EN(1)) dut (
        .GCLK(GCLK), .GRST(GRST), .GIVAL(GIVAL), .GIRDY(GIRDY),
        .GID(GID), .GINJE(GINJE), .GINJP(GINJP), .GOVAL(GOVAL),
        .GORDY(GORDY), .GOD(GOD), .GOC(GOC), .GOCNT(GOCNT)
    );

    c499_enc #(.CNT_W(16), .INJ_EN(0)) dut_noinj (
        .GCLK(GCLK), .GRST(GRST), .GIVAL(GIVAL), .GIRDY(GIRDY1),
        .GID(GID), .GINJE(GINJE), .GINJP(GINJP), .GOVAL(GOVAL1),
        .GORDY(GORDY), .GOD(GOD1), .GOC(GOC1), .GOCNT(GOCNT1)
    );

    function automatic logic [7:0] enc(input logic [31:0] d);
        logic [7:0] f, e, g, c;
        for (int k = 0; k < 8; k++)
            f[k] = d[4*k] ^ d[4*k+1] ^ d[4*k+2] ^ d[4*k+3];
        for (int i = 0; i < 4; i++) begin
            e[i]   = d[i] ^ d[i+4] ^ d[i+8] ^ d[i+12];
            e[i+4] = d[i+16] ^ d[i+20] ^ d[i+24] ^ d[i+28];
        end
        g = {f[5]^f[7], f[4]^f[6], f[6]^f[7], f[4]^f[5],
             f[1]^f[3], f[0]^f[2], f[2]^f[3], f[0]^f[1]};
        c = {e[7]^g[3], e[6]^g[2], e[5]^g[1], e[4]^g[0],
             e[3]^g[7], e[2]^g[6], e[1]^g[5], e[0]^g[4]};
        return c;
    endfunction

    // Single-error corrector: flip the data bit whose H column equals the syndrome.
    function automatic logic [31:0] corr(input logic [31:0] d, input logic [7:0] c);
        logic [7:0]  syn;
        logic [31:0] r;
        syn = c ^ enc(d);
        r = d;
        if (syn != 8'h00)
            for (int j = 0; j < 32; j++)
                if (enc(32'h1 << j) == syn) r[j] = ~r[j];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic        inj;
        logic [5:0]  p;
        logic [31:0] ed;
        logic [7:0]  ec;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int widx, ridx, sent, got;
        logic held, saw_block;
        logic [31:0] prev_d;
        logic [7:0]  prev_c;

        tbl[0]  = '{32'h00000000, 1'b0, 6'd0,  32'h00000000, 8'h00};
        tbl[1]  = '{32'h00000001, 1'b0, 6'd0,  32'h00000001, 8'h51};
        tbl[2]  = '{32'h00010000, 1'b0, 6'd0,  32'h00010000, 8'h15};
        tbl[3]  = '{32'hFFFFFFFF, 1'b0, 6'd0,  32'hFFFFFFFF, 8'h00};
        tbl[4]  = '{32'h80000000, 1'b0, 6'd0,  32'h80000000, 8'h8A};
        tbl[5]  = '{32'h00000001, 1'b1, 6'd5,  32'h00000021, 8'h51};
        tbl[6]  = '{32'h00000001, 1'b1, 6'd35, 32'h00000001, 8'h59};
        tbl[7]  = '{32'h00000001, 1'b1, 6'd50, 32'h00000001, 8'h51};
        tbl[8]  = '{32'h00000001, 1'b0, 6'd5,  32'h00000001, 8'h51};
        tbl[9]  = '{32'h00000000, 1'b1, 6'd39, 32'h00000000, 8'h80};
        tbl[10] = '{32'h00000000, 1'b1, 6'd0,  32'h00000001, 8'h00};

        repeat (2) @(posedge GCLK);
        #1 GRST = 1'b0;
        chk("rst_goval", GOVAL, 1'b0);
        chk("rst_girdy", GIRDY, 1'b1);
        chk("rst_gocnt", GOCNT, 4'd0);
        chk("rst_god", GOD, 32'h0);
        chk("rst_goc", GOC, 8'h0);

        GORDY = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(posedge GCLK); #1;
            GIVAL = 1'b1; GID = tbl[i].d;
            GINJE = tbl[i].inj; GINJP = tbl[i].p;
            #1 chk($sformatf("v%0d_girdy", i), GIRDY, 1'b1);
            @(posedge GCLK); #1;
            GIVAL = 1'b0; GINJE = 1'b0;
            chk($sformatf("v%0d_lat1", i), GOVAL, 1'b0);
            @(posedge GCLK); #1;
            chk($sformatf("v%0d_goval", i), GOVAL, 1'b1);
            chk($sformatf("v%0d_god", i), GOD, tbl[i].ed);
            chk($sformatf("v%0d_goc", i), GOC, tbl[i].ec);
            chk($sformatf("v%0d_corr", i), corr(GOD, GOC), tbl[i].d);
            chk($sformatf("v%0d_noinj_d", i), GOD1, tbl[i].d);
            chk($sformatf("v%0d_noinj_c", i), GOC1, enc(tbl[i].d));
        end

        // Back-to-back words with a 3-cycle downstream stall.
        @(posedge GCLK); #1 GRST = 1'b1;
        @(posedge GCLK); #1 GRST = 1'b0;
        widx = 0; ridx = 0; held = 1'b0; saw_block = 1'b0;
        prev_d = '0; prev_c = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge GCLK); #1;
            GIVAL = (widx < 4);
            GID = 32'(widx + 1);
            GORDY = !(cyc >= 3 && cyc <= 5);
            #1;
            if (held) begin
                chk("stall_goval", GOVAL, 1'b1);
                chk("stall_god", GOD, prev_d);
                chk("stall_goc", GOC, prev_c);
            end
            if (GIVAL && !GIRDY) saw_block = 1'b1;
            if (GOVAL && GORDY) begin
                chk($sformatf("order%0d_d", ridx), GOD, 32'(ridx + 1));
                chk($sformatf("order%0d_c", ridx), GOC, enc(32'(ridx + 1)));
                ridx++;
            end
            held = GOVAL && !GORDY;
            prev_d = GOD; prev_c = GOC;
            if (GIVAL && GIRDY) widx++;
            if (ridx == 4) break;
        end
        GIVAL = 1'b0;
        chk("stall_all_out", ridx, 4);
        chk("stall_blocked", saw_block, 1'b1);
        @(posedge GCLK); #1;
        chk("stall_gocnt", GOCNT, 4'd4);

        // Reset with two words in flight and a would-be handshake.
        GORDY = 1'b0;
        GIVAL = 1'b1; GID = 32'hA5A5A5A5;
        @(posedge GCLK); #1 GID = 32'h5A5A5A5A;
        @(posedge GCLK); #1;
        chk("pre_rst_girdy", GIRDY, 1'b0);
        GORDY = 1'b1; GID = 32'h12345678; GRST = 1'b1;
        @(posedge GCLK); #1;
        GRST = 1'b0; GIVAL = 1'b0;
        chk("flush_goval", GOVAL, 1'b0);
        chk("flush_girdy", GIRDY, 1'b1);
        chk("flush_gocnt", GOCNT, 4'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge GCLK); #1;
            chk($sformatf("flush_idle%0d", k), GOVAL, 1'b0);
        end

        // 17 output handshakes wrap the 4-bit counter to 1.
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge GCLK); #1;
            GIVAL = (sent < 17);
            GID = 32'(sent);
            GORDY = 1'b1;
            #1;
            if (GIVAL && GIRDY) sent++;
            if (GOVAL && GORDY) got++;
            if (got == 17) break;
        end
        GIVAL = 1'b0;
        chk("wrap_got", got, 17);
        @(posedge GCLK); #1;
        chk("wrap_gocnt", GOCNT, 4'd1);
        chk("wide_gocnt", GOCNT1, 16'd17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/c499_enc.md
Name: c499_enc

Overview:
- Streaming SEC check-bit generator; the transmit-side counterpart of the c499 32-bit single-error corrector.
- Accepts 32-bit data words over a valid/ready handshake.
- Computes the 8 check bits GIC[7:0] so that a word fed to c499 with GR=1 yields a zero syndrome.
- Emits data plus check bits through a 2-stage registered pipeline.
- Optional single-bit error injection is applied at the output, so the corrector can be exercised end-to-end.

Parameters:
- CNT_W, 16, width of the output-word counter GOCNT.
- INJ_EN, 1: 1 = injection logic present; 0 = GINJE ignored and no bit is ever flipped.

Ports:
- GCLK  input  1  clock; all state changes on the rising edge.
- GRST  input  1  synchronous reset, active-high.
- GIVAL  input  1  input word valid.
- GIRDY  output  1  block can accept a word this cycle.
- GID  input  32  data word; bit k = GIDk.
- GINJE  input  1  request to inject an error into this word; sampled with GIVAL&GIRDY.
- GINJP  input  6  injection position: 0-31 = data bit, 32-39 = check bit (pos-32), 40-63 = no flip.
- GOVAL  output  1  output codeword valid.
- GORDY  input  1  downstream ready.
- GOD  output  32  data out.
- GOC  output  8  check bits out; connect to GIC0..GIC7.
- GOCNT  output  CNT_W  count of completed output handshakes.

Behaviour:
- Check-bit arithmetic, all XOR, D = GID:
  - Fk = D[4k]^D[4k+1]^D[4k+2]^D[4k+3], k=0..7.
  - G0=F0^F1, G1=F2^F3, G2=F0^F2, G3=F1^F3.
  - G4=F4^F5, G5=F6^F7, G6=F4^F6, G7=F5^F7.
  - Ei = D[i]^D[i+4]^D[i+8]^D[i+12], i=0..3.
  - Ei = D[i+12]^D[i+16]^D[i+20]^D[i+24], i=4..7 (E4 = D16^D20^D24^D28 … E7 = D19^D23^D27^D31).
  - C0=E0^G4, C1=E1^G5, C2=E2^G6, C3=E3^G7.
  - C4=E4^G0, C5=E5^G1, C6=E6^G2, C7=E7^G3.
- Stage 1 register (s1): valid s1_v, data, F[7:0], E[7:0], injection flag and position.
- Stage 2 register (s2): valid s2_v, GOD, GOC (injection already applied). GOVAL = s2_v. Outputs are driven straight from flops.
- Advance rules:
  - adv2 = !s2_v | GORDY.
  - adv1 = !s1_v | adv2.
  - GIRDY = adv1 (combinational from state and GORDY).
- Input handshake GIVAL&GIRDY loads s1; s1_v <= GIVAL when adv1. s2 loads from s1 when adv2.
- Latency: a word accepted in cycle N is presented with GOVAL=1 in cycle N+2 when there is no stall.
- Throughput: one word per cycle while GORDY=1.
- Stall: while GOVAL=1 and GORDY=0, GOD/GOC/GOVAL hold stable. At most 2 words are in flight; GIRDY=0 when both stages are full and GORDY=0.
- Dropped words: GIVAL=0 in a cycle with adv1=1 inserts a bubble; no word is ever duplicated or dropped.
- Injection: when the s1 flag is set and INJ_EN=1, exactly one bit is inverted on the s1->s2 transfer (GOD[p] for p<32, GOC[p-32] for 32≤p≤39); positions ≥40 flip nothing. The flag applies to that word only.
- GOCNT: +1 on every GOVAL&GORDY cycle; wraps from 2^CNT_W-1 to 0; never saturates.
- Reset: GRST=1 at an edge clears s1_v, s2_v, GOD, GOC and GOCNT to 0. In-flight words are discarded.
  - During reset: GOVAL=0.
  - GIRDY = 1 while both valids are 0, including the cycle after reset.
  - Reset overrides a simultaneous handshake.

Test Plan:
- D=0x00000000, no injection -> GOD=0x00000000, GOC=0x00; appears 2 cycles after acceptance.
- D=0x00000001 -> GOC=0x51. D=0x00010000 -> GOC=0x15. D=0xFFFFFFFF -> GOC=0x00. Every output fed to a c499 model with GR=1 returns GOD equal to the input.
- Back-to-back words 1,2,3,4 with GORDY low on cycles 3-5:
  - outputs hold stable while stalled;
  - GIRDY drops once 2 words are buffered;
  - order is preserved;
  - GOCNT=4 at the end.
- GINJE=1 with GINJP=5, 35 and 50 on D=0x00000001:
  - GINJP=5 -> GOD=0x00000021, GOC=0x51; c499 restores 0x00000001.
  - GINJP=35 -> GOC=0x59.
  - GINJP=50 -> unmodified output.
  - The next word carries no flip.
- Assert GRST with two words in flight -> next cycle GOVAL=0, GIRDY=1, GOCNT=0; the words are never emitted.
- CNT_W=4, 17 output handshakes -> GOCNT=1 (wrapped through 15 -> 0).
